lcd_spi_rx: RTL

- Receive-side counterpart of the LCD SPI writer: decodes the 4-wire LCD bus (cs, dc, sclk, mosi) back into 9-bit words `{dc, byte}`.
- Parses the ST7789-style command stream into window set-up and RGB565 pixel writes with x/y coordinates.
- Used as a display emulator or monitor on the LCD pins, for on-chip loopback checking and simulation scoreboarding.
- Runs entirely in the system clock domain; the SPI pins are asynchronous inputs.

---
 rtl/lcd_spi_rx_pkg.sv | 31 +++
 rtl/lcd_spi_deser.sv | 84 ++++++++
 rtl/lcd_spi_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lcd_spi_rx_pkg.sv
// Shared definitions for the LCD SPI receiver: command codes, parser
// states and the layout of the 9-bit {dc, byte} bus word.
package lcd_spi_rx_pkg;

  // ST7789-style command codes understood by the parser
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  // Bus word layout: bit 8 carries dc, bits 7:0 the byte
  localparam int WORD_W = 9;
  localparam int DC_BIT = 8;

  // Default panel geometry
  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;

  // Command-stream parser states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CASET_P = 2'd1,
    ST_RASET_P = 2'd2,
    ST_RAMWR   = 2'd3
  } parser_state_t;

  // True when a word is a command (dc low)
  function automatic logic is_cmd(input logic [WORD_W-1:0] word);
    return ~word[DC_BIT];
  endfunction

endpackage

// File: rtl/lcd_spi_deser.sv
// SPI front end: synchronizes the asynchronous LCD pins into the system
// clock domain, detects sclk rising edges and assembles MSB-first bytes
// tagged with the dc level seen on the 8th edge.
module lcd_spi_deser
  import lcd_spi_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              dc,
  input  logic              sclk,
  input  logic              mosi,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              part_err
);

  // Two-stage synchronizers; cs idles high so it resets to 1
  logic cs_meta, cs_sync;
  logic dc_meta, dc_sync;
  logic mosi_meta, mosi_sync;
  logic sclk_meta, sclk_sync, sclk_prev;

  logic       sclk_rise;
  logic [2:0] bit_cnt;
  logic [6:0] shift;

  // Pin synchronizers plus a third sclk stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      dc_meta   <= 1'b0;
      dc_sync   <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      dc_meta   <= dc;
      dc_sync   <= dc_meta;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
    end
  end

  // Mode 0: data is valid on the rising edge of sclk
  assign sclk_rise = sclk_sync & ~sclk_prev;

  // Shift in bits while cs is low; a cs release drops any partial byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      part_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      part_err <= 1'b0;
      if (cs_sync) begin
        // Bytes never straddle a cs deassertion
        if (bit_cnt != 3'd0) begin
          part_err <= 1'b1;
        end
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_sync};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {dc_sync, shift, mosi_sync};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI receiver / display emulator: turns the 4-wire LCD bus back into
// {dc, byte} words, tracks the CASET/RASET window and reports every RGB565
// pixel written by RAMWR together with its x/y coordinate.
module lcd_spi_rx
  import lcd_spi_rx_pkg::*;
#(
  parameter int         H_RES     = lcd_spi_rx_pkg::H_RES_DEF,
  parameter int         V_RES     = lcd_spi_rx_pkg::V_RES_DEF,
  parameter logic [7:0] CMD_CASET = lcd_spi_rx_pkg::CMD_CASET,
  parameter logic [7:0] CMD_RASET = lcd_spi_rx_pkg::CMD_RASET,
  parameter logic [7:0] CMD_RAMWR = lcd_spi_rx_pkg::CMD_RAMWR
) (
  input  logic              sys_clk_50MHz,
  input  logic              sys_rst_n,
  input  logic              cs,
  input  logic              dc,
  input  logic              sclk,
  input  logic              mosi,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              cmd_valid,
  output logic              pixel_valid,
  output logic [8:0]        pixel_x,
  output logic [8:0]        pixel_y,
  output logic [15:0]       pixel_rgb,
  output logic              frame_done,
  output logic              proto_err
);

  localparam logic [8:0] XE_RST = 9'(H_RES - 1);
  localparam logic [8:0] YE_RST = 9'(V_RES - 1);

  logic part_err;

  lcd_spi_deser u_deser (
    .clk      (sys_clk_50MHz),
    .rst_n    (sys_rst_n),
    .cs       (cs),
    .dc       (dc),
    .sclk     (sclk),
    .mosi     (mosi),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .part_err (part_err)
  );

  parser_state_t state;

  // Address window and current write pointer
  logic [8:0] xs, xe, ys, ye;
  logic [8:0] x, y;

  // Parameter collection: only the bits that reach the 9-bit window
  logic [1:0] param_cnt;
  logic       p0_bit;
  logic [7:0] p1_byte;
  logic       p2_bit;

  // Pixel byte phase: high byte held until the low byte arrives
  logic       pix_phase;
  logic [7:0] pix_hi;

  logic [7:0] rx_byte;
  logic       rx_is_cmd;
  logic       at_xe, at_ye;

  assign rx_byte   = rx_data[7:0];
  assign rx_is_cmd = is_cmd(rx_data);
  assign at_xe     = (x == xe);
  assign at_ye     = (y == ye);

  // Command parser, window registers and pixel address generator
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      xs          <= 9'd0;
      xe          <= XE_RST;
      ys          <= 9'd0;
      ye          <= YE_RST;
      x           <= 9'd0;
      y           <= 9'd0;
      param_cnt   <= 2'd0;
      p0_bit      <= 1'b0;
      p1_byte     <= 8'd0;
      p2_bit      <= 1'b0;
      pix_phase   <= 1'b0;
      pix_hi      <= 8'd0;
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_x     <= 9'd0;
      pixel_y     <= 9'd0;
      pixel_rgb   <= 16'd0;
      frame_done  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;

      if (part_err) begin
        proto_err <= 1'b1;
      end

      if (rx_valid) begin
        if (rx_is_cmd) begin
          // A command always wins, whatever was in progress
          cmd_valid <= 1'b1;
          if (state == ST_CASET_P || state == ST_RASET_P ||
              (state == ST_RAMWR && pix_phase)) begin
            proto_err <= 1'b1;
          end
          param_cnt <= 2'd0;
          pix_phase <= 1'b0;
          if (rx_byte == CMD_CASET) begin
            state <= ST_CASET_P;
          end else if (rx_byte == CMD_RASET) begin
            state <= ST_RASET_P;
          end else if (rx_byte == CMD_RAMWR) begin
            state <= ST_RAMWR;
            x     <= xs;
            y     <= ys;
          end else begin
            state <= ST_IDLE;
          end
        end else begin
          case (state)
            ST_CASET_P, ST_RASET_P: begin
              case (param_cnt)
                2'd0: p0_bit  <= rx_byte[0];
                2'd1: p1_byte <= rx_byte;
                2'd2: p2_bit  <= rx_byte[0];
                default: begin
                  // Window commits only once all four bytes are in
                  if (state == ST_CASET_P) begin
                    xs <= {p0_bit, p1_byte};
                    xe <= {p2_bit, rx_byte};
                  end else begin
                    ys <= {p0_bit, p1_byte};
                    ye <= {p2_bit, rx_byte};
                  end
                  state <= ST_IDLE;
                end
              endcase
              param_cnt <= param_cnt + 2'd1;
            end
            ST_RAMWR: begin
              if (!pix_phase) begin
                pix_hi    <= rx_byte;
                pix_phase <= 1'b1;
              end else begin
                pix_phase   <= 1'b0;
                pixel_valid <= 1'b1;
                pixel_rgb   <= {pix_hi, rx_byte};
                pixel_x     <= x;
                pixel_y     <= y;
                frame_done  <= at_xe & at_ye;
                // Raster advance; an inverted window wraps through 511
                if (at_xe) begin
                  x <= xs;
                  y <= at_ye ? ys : y + 9'd1;
                end else begin
                  x <= x + 9'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
